// File: rtl/uart_ctrl.sv
// uart_ctrl: full-duplex UART with a run-time baud divisor, optional even/odd
// parity, one or two TX stop bits, and RX parity/framing error reporting.
// One free-running tick generator paces both directions; every bit lasts
// OVERSAMPLE ticks. TX and RX are independent state machines sharing that tick.
module uart_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_in,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_out,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  rx_valid,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  // Tick index of the last tick of a bit, and of the mid-bit sample point
  // counted from the tick on which the start edge was first seen.
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Baud tick generator
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick;

  // A new baud_div is only compared against, never loaded, so a counter that is
  // already past a smaller value simply runs up to all-ones and wraps to zero.
  assign tick = (div_cnt == baud_div);

  // Free-running divider: 0..baud_div, one tick per wrap.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_t             tx_state, tx_state_n;
  logic [TW-1:0]         tx_tick_cnt, tx_tick_n;
  logic [BW-1:0]         tx_bit_cnt, tx_bit_n;
  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;
  logic                  tx_par_bit, tx_par_bit_n;
  logic                  tx_par_en, tx_par_en_n;
  logic                  tx_stop2, tx_stop2_n;
  logic                  tx_out_n, tx_done_n;
  logic                  tx_bit_end;

  assign tx_bit_end = tick && (tx_tick_cnt == TICK_LAST);

  // TX next-state: frame sequencing and the value the pin takes next cycle.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    tx_state_n   = tx_state;
    tx_tick_n    = tx_tick_cnt;
    tx_bit_n     = tx_bit_cnt;
    tx_shift_n   = tx_shift;
    tx_par_bit_n = tx_par_bit;
    tx_par_en_n  = tx_par_en;
    tx_stop2_n   = tx_stop2;
    tx_done_n    = 1'b0;

    if (tick && (tx_state != TX_IDLE)) begin
      tx_tick_n = (tx_tick_cnt == TICK_LAST) ? '0 : tx_tick_cnt + TW'(1);
    end

    case (tx_state)
      TX_IDLE: begin
        if (tx_start) begin
          // Frame contents and format are frozen here for the whole frame.
          tx_state_n   = TX_START;
          tx_tick_n    = '0;
          tx_bit_n     = '0;
          tx_shift_n   = tx_in;
          tx_par_bit_n = (^tx_in) ^ parity_odd;
          tx_par_en_n  = parity_en;
          tx_stop2_n   = stop2;
        end
      end
      TX_START: begin
        if (tx_bit_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_n = tx_shift >> 1;
          if (tx_bit_cnt == BIT_LAST) begin
            tx_bit_n   = '0;
            tx_state_n = tx_par_en ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_n = tx_bit_cnt + BW'(1);
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) tx_state_n = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop2 && (tx_bit_cnt == '0)) begin
            tx_bit_n = BW'(1);
          end else begin
            tx_state_n = TX_IDLE;
            tx_done_n  = 1'b1;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase

    // The pin is registered from the next state so it never glitches.
    case (tx_state_n)
      TX_START:  tx_out_n = 1'b0;
      TX_DATA:   tx_out_n = tx_shift_n[0];
      TX_PARITY: tx_out_n = tx_par_bit_n;
      default:   tx_out_n = 1'b1;
    endcase
  end

  // TX state register; reset forces the line idle-high at once.
  // NOTE: the data shift registers are reset as well; they are plain flops,
  // not a memory, so clearing them costs nothing and keeps outputs defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shift    <= '0;
      tx_par_bit  <= 1'b0;
      tx_par_en   <= 1'b0;
      tx_stop2    <= 1'b0;
      tx_out      <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      tx_state    <= tx_state_n;
      tx_tick_cnt <= tx_tick_n;
      tx_bit_cnt  <= tx_bit_n;
      tx_shift    <= tx_shift_n;
      tx_par_bit  <= tx_par_bit_n;
      tx_par_en   <= tx_par_en_n;
      tx_stop2    <= tx_stop2_n;
      tx_out      <= tx_out_n;
      tx_busy     <= (tx_state_n != TX_IDLE);
      tx_done     <= tx_done_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [1:0]            rx_sync;
  logic                  rx_line;
  rx_state_t             rx_state, rx_state_n;
  logic [TW-1:0]         rx_tick_cnt, rx_tick_n;
  logic [BW-1:0]         rx_bit_cnt, rx_bit_n;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
  logic                  rx_par_en, rx_par_en_n;
  logic                  rx_par_odd, rx_par_odd_n;
  logic                  rx_perr_pend, rx_perr_pend_n;
  logic                  rx_armed, rx_armed_n;
  logic [DATA_WIDTH-1:0] rx_out_n;
  logic                  rx_valid_n, rx_parity_err_n, rx_frame_err_n;
  logic                  rx_mid, rx_bit_end;

  assign rx_line    = rx_sync[1];
  assign rx_mid     = tick && (rx_tick_cnt == TICK_MID);
  assign rx_bit_end = tick && (rx_tick_cnt == TICK_LAST);

  // Two-flop synchronizer for the asynchronous serial input, idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], rx_in};
    end
  end

  // RX next-state: start qualification, mid-bit sampling and word delivery.
  // rx_armed is cleared when a stop bit is seen low, so a held break yields
  // exactly one word and the receiver waits for the line to go high again.
  always_comb begin
    rx_state_n      = rx_state;
    rx_tick_n       = rx_tick_cnt;
    rx_bit_n        = rx_bit_cnt;
    rx_shift_n      = rx_shift;
    rx_par_en_n     = rx_par_en;
    rx_par_odd_n    = rx_par_odd;
    rx_perr_pend_n  = rx_perr_pend;
    rx_armed_n      = rx_armed;
    rx_out_n        = rx_out;
    rx_parity_err_n = rx_parity_err;
    rx_frame_err_n  = rx_frame_err;
    rx_valid_n      = 1'b0;

    if (tick && (rx_state != RX_IDLE)) begin
      rx_tick_n = (rx_tick_cnt == TICK_LAST) ? '0 : rx_tick_cnt + TW'(1);
    end

    case (rx_state)
      RX_IDLE: begin
        if (rx_line) rx_armed_n = 1'b1;
        if (tick && rx_armed && !rx_line) begin
          rx_state_n     = RX_START;
          rx_tick_n      = '0;
          rx_bit_n       = '0;
          rx_par_en_n    = parity_en;
          rx_par_odd_n   = parity_odd;
          rx_perr_pend_n = 1'b0;
        end
      end
      RX_START: begin
        if (rx_mid) begin
          // A line back high at mid start bit was a glitch, not a frame.
          rx_state_n = rx_line ? RX_IDLE : RX_DATA;
          rx_tick_n  = '0;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_shift_n = {rx_line, rx_shift[DATA_WIDTH-1:1]};
          if (rx_bit_cnt == BIT_LAST) begin
            rx_bit_n   = '0;
            rx_state_n = rx_par_en ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_n = rx_bit_cnt + BW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_perr_pend_n = rx_line ^ (^rx_shift) ^ rx_par_odd;
          rx_state_n     = RX_STOP;
        end
      end
      RX_STOP: begin
        // Only the first stop bit is checked; leaving at mid-bit gives the
        // receiver half a bit of margin to catch the next start edge.
        if (rx_bit_end) begin
          rx_state_n      = RX_IDLE;
          rx_out_n        = rx_shift;
          rx_parity_err_n = rx_perr_pend;
          rx_frame_err_n  = !rx_line;
          rx_valid_n      = 1'b1;
          rx_armed_n      = rx_line;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX state register and registered client-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RX_IDLE;
      rx_tick_cnt   <= '0;
      rx_bit_cnt    <= '0;
      rx_shift      <= '0;
      rx_par_en     <= 1'b0;
      rx_par_odd    <= 1'b0;
      rx_perr_pend  <= 1'b0;
      rx_armed      <= 1'b1;
      rx_out        <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_state      <= rx_state_n;
      rx_tick_cnt   <= rx_tick_n;
      rx_bit_cnt    <= rx_bit_n;
      rx_shift      <= rx_shift_n;
      rx_par_en     <= rx_par_en_n;
      rx_par_odd    <= rx_par_odd_n;
      rx_perr_pend  <= rx_perr_pend_n;
      rx_armed      <= rx_armed_n;
      rx_out        <= rx_out_n;
      rx_valid      <= rx_valid_n;
      rx_parity_err <= rx_parity_err_n;
      rx_frame_err  <= rx_frame_err_n;
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed scenarios for uart_ctrl at baud_div=0, OVERSAMPLE=16.
// A frame-level model predicts tx_out/tx_busy/tx_done every cycle and a queue
// of expected received words predicts rx_out and the error flags.
module tb_uart_ctrl;

  localparam int DW = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   baud_div = '0;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          stop2 = 1'b0;
  logic          tx_start = 1'b0;
  logic [DW-1:0] tx_in = '0;
  logic          tx_busy, tx_done, tx_out;
  logic          rx_in;
  logic [DW-1:0] rx_out;
  logic          rx_valid, rx_parity_err, rx_frame_err;

  logic loop = 1'b1;
  logic rx_drv = 1'b1;
  assign rx_in = loop ? tx_out : rx_drv;

  uart_ctrl #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .tx_start(tx_start), .tx_in(tx_in),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_out(tx_out),
    .rx_in(rx_in), .rx_out(rx_out), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
  } rx_exp_t;

  rx_exp_t rx_q[$];
  logic    m_bits [0:12];
  int      m_len;
  int      m_cyc;
  bit      m_busy;
  bit      m_done;

  function automatic void build_frame(input logic [DW-1:0] d, input logic pe,
                                      input logic po, input logic s2);
    int n;
    m_bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) m_bits[1 + i] = d[i];
    n = 1 + DW;
    if (pe) begin m_bits[n] = (^d) ^ po; n++; end
    m_bits[n] = 1'b1; n++;
    if (s2) begin m_bits[n] = 1'b1; n++; end
    m_len = n;
  endfunction

  // Frame model: a frame is m_len bits of OS cycles, starting the cycle after
  // acceptance; tx_done marks the first cycle after the last bit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cyc  = 0;
      rx_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cyc++;
        if (m_cyc == m_len * OS) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (tx_start) begin
        build_frame(tx_in, parity_en, parity_odd, stop2);
        m_busy = 1'b1;
        m_cyc  = 0;
        if (loop) rx_q.push_back('{d: tx_in, pe: 1'b0, fe: 1'b0});
      end
    end
  end

  // ------------------------------------------------------- compare process
  logic [DW-1:0] last_out;
  logic          last_pe, last_fe;
  logic          prev_valid;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_out   = '0;
      last_pe    = 1'b0;
      last_fe    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      check("tx_out", tx_out, m_busy ? m_bits[m_cyc / OS] : 1'b1);
      check("tx_busy", tx_busy, m_busy);
      check("tx_done", tx_done, m_done);
      if (rx_valid) begin
        check("rx_valid_pulse", prev_valid, 1'b0);
        if (rx_q.size() == 0) begin
          check("rx_valid_unexpected", rx_valid, 1'b0);
        end else begin
          rx_exp_t e;
          e = rx_q.pop_front();
          last_out = e.d;
          last_pe  = e.pe;
          last_fe  = e.fe;
        end
      end
      check("rx_out", rx_out, last_out);
      check("rx_parity_err", rx_parity_err, last_pe);
      check("rx_frame_err", rx_frame_err, last_fe);
      prev_valid = rx_valid;
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic send(input logic [DW-1:0] d);
    @(negedge clk);
    tx_in    = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (tx_done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (tx_done !== 1'b1) check("tx_done_timeout", tx_done, 1'b1);
  endtask

  task automatic wait_rx();
    int k = 0;
    while (rx_q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("rx_missing_words", rx_q.size(), 0);
  endtask

  task automatic drive_bit(input logic v);
    rx_drv = v;
    repeat (OS) @(negedge clk);
  endtask

  // Hand-built frame on rx_in, optionally with a wrong parity or stop bit.
  task automatic drive_frame(input logic [DW-1:0] d, input bit bad_par, input bit bad_stop);
    rx_exp_t e;
    e.d  = d;
    e.pe = parity_en & bad_par;
    e.fe = bad_stop;
    rx_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (parity_en) drive_bit(((^d) ^ parity_odd) ^ bad_par);
    drive_bit(!bad_stop);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  int n, n0;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_out", tx_out, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_rx_out", rx_out, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_errs", {rx_parity_err, rx_frame_err}, 2'b00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 loopback of 0xA5
    send(8'hA5);
    wait_done(n);
    check("len_8n1", n, 160);
    wait_rx();
    check("rx_a5", rx_out, 8'hA5);

    // 8E2 of 0x07, then 8O2
    parity_en = 1'b1; stop2 = 1'b1; parity_odd = 1'b0;
    send(8'h07);
    check("par_even_bit", m_bits[9], 1'b1);
    wait_done(n);
    check("len_8e2", n, 192);
    wait_rx();
    check("rx_07_even", {rx_out, rx_parity_err, rx_frame_err}, {8'h07, 2'b00});
    parity_odd = 1'b1;
    send(8'h07);
    check("par_odd_bit", m_bits[9], 1'b0);
    wait_done(n);
    check("len_8o2", n, 192);
    wait_rx();

    // Direct drive: parity error, frame error, then a clean frame clears both
    loop = 1'b0; stop2 = 1'b0; parity_odd = 1'b0;
    @(negedge clk);
    drive_frame(8'h07, 1'b1, 1'b0);
    wait_rx();
    check("perr_set", {rx_out, rx_parity_err}, {8'h07, 1'b1});
    drive_frame(8'h55, 1'b0, 1'b1);
    wait_rx();
    check("ferr_set", rx_frame_err, 1'b1);
    drive_frame(8'hC3, 1'b0, 1'b0);
    wait_rx();
    check("errs_cleared", {rx_parity_err, rx_frame_err}, 2'b00);

    // Break: one zero word with frame error, no re-arm while the line is low
    parity_en = 1'b0;
    rx_q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    rx_drv = 1'b0;
    repeat (OS * 14) @(negedge clk);
    rx_drv = 1'b1;
    repeat (OS * 2) @(negedge clk);
    wait_rx();
    check("break_word", {rx_out, rx_frame_err}, {8'h00, 1'b1});
    drive_frame(8'h69, 1'b0, 1'b0);
    wait_rx();

    // False start on RX while TX sends independently
    fork
      begin
        send(8'h81);
        wait_done(n0);
        check("len_concurrent", n0, 160);
      end
      begin
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        drive_frame(8'h3C, 1'b0, 1'b0);
      end
    join
    wait_rx();
    check("rx_3c", rx_out, 8'h3C);

    // tx_start mid-frame is ignored; back-to-back start after tx_done
    loop = 1'b1;
    send(8'h96);
    repeat (50) @(negedge clk);
    tx_in    = 8'hFF;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done(n);
    tx_in    = 8'h34;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("b2b_start_bit", tx_out, 1'b0);
    wait_done(n);
    check("len_b2b", n, 160);
    wait_rx();
    check("rx_34", rx_out, 8'h34);

    // Reset mid-TX / mid-RX, then a clean transfer
    send(8'hC3);
    repeat (80) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_tx_out", tx_out, 1'b1);
    check("rst_mid_tx_busy", tx_busy, 1'b0);
    check("rst_mid_rx_valid", rx_valid, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    send(8'h5A);
    wait_done(n);
    wait_rx();
    check("rx_5a", rx_out, 8'h5A);

    repeat (20) @(negedge clk);
    check("rx_q_final", rx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
